// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state type, default sizes and length clamp for seq_detect_ctrl
package seq_detect_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SEQ_W_DEF  = 15;
    localparam int DATA_W_DEF = 8;

    // Zero means "one bit"; anything beyond the history depth uses the full depth.
    function automatic int clamp_len(input int len, input int max);
        if (len < 1) begin
            return 1;
        end
        if (len > max) begin
            return max;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_shift_cmp.sv
// rtl/seq_shift_cmp.sv - history shift register, fill counter and registered masked pattern compare
module seq_shift_cmp #(
    parameter int SEQ_W = 15,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [SEQ_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             detected
);

    logic [SEQ_W-1:0] history;
    logic [SEQ_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic             new_bit;
    logic             match;

    always_comb begin
        mask = '0;
        for (int i = 0; i < SEQ_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        match = (((history ^ pattern) & mask) == '0) && (fill >= len);
    end

    // Only a freshly shifted bit may report, so a static history cannot re-fire in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history  <= '0;
            fill     <= '0;
            new_bit  <= 1'b0;
            detected <= 1'b0;
        end else begin
            detected <= new_bit & match;
            new_bit  <= shift_en & ~clr;
            if (clr) begin
                history <= '0;
                fill    <= '0;
            end else if (shift_en) begin
                history <= {history[SEQ_W-2:0], bit_in};
                if (fill != LEN_W'(SEQ_W)) begin
                    fill <= fill + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - word handshake, MSB-first serialiser and config for the pattern matcher (option: SEQ_MATCH_CNT_EN)
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEQ_W  = SEQ_W_DEF,
    parameter int LEN_W  = $clog2(SEQ_W + 1)
`ifdef SEQ_MATCH_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [SEQ_W-1:0]  cfg_seq,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              detected,
    output logic              busy
`ifdef SEQ_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]  match_cnt
`endif
);

    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg;
    logic [BC_W-1:0]   bit_cnt;
    logic [SEQ_W-1:0]  pattern_q;
    logic [LEN_W-1:0]  len_q;
    logic              last_bit;
    logic              load;
    logic              cfg_accept;
    logic              shift_en;

    assign last_bit = (bit_cnt == BC_W'(DATA_W - 1));
    assign shift_en = (state_q == SHIFT);
    assign busy     = (state_q == SHIFT);

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        load       = 1'b0;
        cfg_accept = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready   = enable & rst_n;
                cfg_accept = cfg_we;
                if (in_valid && in_ready) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Reloading on the last bit keeps back-to-back words bubble-free.
                if (last_bit) begin
                    in_ready = enable & rst_n;
                    if (in_valid && in_ready) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            pattern_q <= '0;
            len_q     <= LEN_W'(1);
        end else begin
            state_q <= state_d;
            if (load) begin
                shreg   <= in_data;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + BC_W'(1);
            end
            if (cfg_accept) begin
                pattern_q <= cfg_seq;
                len_q     <= LEN_W'(clamp_len(int'(cfg_len), SEQ_W));
            end
        end
    end

    seq_shift_cmp #(
        .SEQ_W (SEQ_W),
        .LEN_W (LEN_W)
    ) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cfg_accept),
        .shift_en (shift_en),
        .bit_in   (shreg[DATA_W-1]),
        .pattern  (pattern_q),
        .len      (len_q),
        .detected (detected)
    );

`ifdef SEQ_MATCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (cfg_accept) begin
            match_cnt <= '0;
        end else if (detected && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
